simmem_id_queue_bank: RTL and testbench

// - Per-ID FIFO store for the simulated memory controller: accepts tagged structs, keeps one in-order linked list per AXI ID in a shared pool, releases heads under releaser control.
// - Sits between the request/response path and the delay releaser.
// - Successor to the single-priority list bank, with these additions: flop-based storage, round-robin release, simultaneous push+pop, per-ID occupancy outputs.

---
 rtl/simmem_id_queue_bank.sv | 106 ++++++++++
 tb/tb_simmem_id_queue_bank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_id_queue_bank.sv
// simmem_id_queue_bank: per-ID FIFO lists in a shared flop pool with round-robin head release; SIMMEM_ID_QUEUE_PER_ID_CAP_EN adds a per-ID occupancy cap
module simmem_id_queue_bank #(
  parameter int StructWidth = 64,
  parameter int IdWidth = 4,
  parameter int TotalCapacity = 128,
  parameter int MaxPerId = 32,
  localparam int NumIds = 2 ** IdWidth,
  localparam int AddrW = $clog2(TotalCapacity)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumIds-1:0]           release_en_i,
  input  logic [StructWidth-1:0]      data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [StructWidth-1:0]      data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NumIds*(AddrW+1)-1:0] id_len_o,
  output logic [AddrW:0]              free_cnt_o
);
  logic [StructWidth-IdWidth-1:0] data_mem [TotalCapacity];
  logic [AddrW-1:0] next_mem [TotalCapacity];
  logic [AddrW-1:0] head_q [NumIds];
  logic [AddrW-1:0] tail_q [NumIds];
  logic [AddrW:0] len_q [NumIds];
  logic [TotalCapacity-1:0] used_q;
  logic [IdWidth-1:0] rr_q, grant, idx, in_id;
  logic [AddrW:0] free_q;
  logic [AddrW-1:0] alloc;
  logic [NumIds-1:0] push_k, pop_k;
  logic push, pop;

  if (TotalCapacity != 2 ** AddrW || TotalCapacity < 2 || MaxPerId < 1) begin : g_bad_cfg
    $error("simmem_id_queue_bank: invalid parameters");
  end

  assign in_id = data_i[IdWidth-1:0];
  assign push = in_valid_i && in_ready_o;
  assign pop = out_valid_o && out_ready_i;
  assign push_k = push ? NumIds'(1) << in_id : '0;
  assign pop_k = pop ? NumIds'(1) << grant : '0;
  assign free_cnt_o = free_q;
  assign data_o = {data_mem[head_q[grant]], grant};

`ifdef SIMMEM_ID_QUEUE_PER_ID_CAP_EN
  assign in_ready_o = (free_q != '0) && (len_q[in_id] < (AddrW+1)'(MaxPerId));
`else
  assign in_ready_o = free_q != '0;
`endif

  for (genvar i = 0; i < NumIds; i++) begin : g_len
    assign id_len_o[i*(AddrW+1) +: AddrW+1] = len_q[i];
  end

  // lowest-index free pool entry; a slot freed by this cycle's pop is still marked used
  always_comb begin
    alloc = '0;
    for (int i = TotalCapacity - 1; i >= 0; i--) if (!used_q[i]) alloc = AddrW'(i);
  end

  // round-robin grant: first eligible ID at or after rr_q, lowest offset wins
  always_comb begin
    grant = rr_q;
    out_valid_o = 1'b0;
    idx = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      idx = rr_q + IdWidth'(i);
      if (release_en_i[idx] && len_q[idx] != '0) begin
        grant = idx;
        out_valid_o = 1'b1;
      end
    end
  end

  // list bookkeeping; a pop that empties a list while the same ID pushes hands the head to the new entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumIds; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        len_q[k] <= '0;
      end
      used_q <= '0;
      rr_q <= '0;
      free_q <= (AddrW+1)'(TotalCapacity);
    end else begin
      for (int k = 0; k < NumIds; k++) begin
        if (pop_k[k]) head_q[k] <= (push_k[k] && len_q[k] == (AddrW+1)'(1)) ? alloc : next_mem[head_q[k]];
        else if (push_k[k] && len_q[k] == '0) head_q[k] <= alloc;
        if (push_k[k]) tail_q[k] <= alloc;
        len_q[k] <= len_q[k] + (AddrW+1)'(push_k[k]) - (AddrW+1)'(pop_k[k]);
      end
      if (push) used_q[alloc] <= 1'b1;
      if (pop) used_q[head_q[grant]] <= 1'b0;
      if (pop) rr_q <= grant + IdWidth'(1);
      free_q <= free_q - (AddrW+1)'(push) + (AddrW+1)'(pop);
    end
  end

  // payload and link storage, not reset
  always_ff @(posedge clk_i) begin
    if (push) data_mem[alloc] <= data_i[StructWidth-1:IdWidth];
    if (push && len_q[in_id] != '0) next_mem[tail_q[in_id]] <= alloc;
  end
endmodule

// File: tb/tb_simmem_id_queue_bank.sv
// tb_simmem_id_queue_bank: randomized bench against a per-ID queue reference model
module tb_simmem_id_queue_bank;
  localparam int SW = 64;
  localparam int IW = 4;
  localparam int NI = 16;
  localparam int MPI = 4;
`ifdef SIMMEM_ID_QUEUE_PER_ID_CAP_EN
  localparam int TC = 64;
`else
  localparam int TC = 128;
`endif
  localparam int AW = $clog2(TC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] release_en = '0;
  logic [SW-1:0] data_i = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [SW-1:0] data_o;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [NI*(AW+1)-1:0] id_len;
  logic [AW:0] free_cnt;

  logic [SW-1:0] mq [NI][$];
  int mrr = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simmem_id_queue_bank #(.StructWidth(SW), .IdWidth(IW), .TotalCapacity(TC), .MaxPerId(MPI)) dut (
    .clk_i(clk), .rst_ni(rst_n), .release_en_i(release_en), .data_i(data_i), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .data_o(data_o), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .id_len_o(id_len), .free_cnt_o(free_cnt));

  function automatic int m_total();
    int t = 0;
    for (int k = 0; k < NI; k++) t += mq[k].size();
    return t;
  endfunction

  function automatic int m_grant();
    for (int i = 0; i < NI; i++) begin
      int k = (mrr + i) % NI;
      if (release_en[k] && mq[k].size() != 0) return k;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
`ifdef SIMMEM_ID_QUEUE_PER_ID_CAP_EN
    return m_total() < TC && mq[data_i[IW-1:0]].size() < MPI;
`else
    return m_total() < TC;
`endif
  endfunction

  function automatic logic [SW-1:0] rdata(int id);
    logic [SW-1:0] d = {$urandom(), $urandom()};
    d[IW-1:0] = IW'(id);
    return d;
  endfunction

  function automatic logic [AW:0] dlen(int k);
    return id_len[k*(AW+1) +: AW+1];
  endfunction

  task automatic tick();
    logic [SW-1:0] d = data_i;
    bit pu = in_valid && m_ready();
    int g = m_grant();
    bit po = (g >= 0) && out_ready;
    @(posedge clk);
    if (po) begin
      mq[g].delete(0);
      mrr = (g + 1) % NI;
    end
    if (pu) mq[d[IW-1:0]].push_back(d);
    #1;
  endtask

  task automatic push(logic [SW-1:0] d);
    in_valid = 1'b1;
    data_i = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    if (free_cnt !== (AW+1)'(TC)) begin failures++; $display("FAIL reset_free act=%0d exp=%0d", free_cnt, TC); end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (dlen(k) !== '0) begin failures++; $display("FAIL reset_len id=%0d act=%0d exp=0", k, dlen(k)); end
    end
  endtask

  task automatic test_in_order();
    logic [SW-1:0] v [3];
    for (int i = 0; i < 3; i++) begin v[i] = rdata(3); push(v[i]); end
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL order_hidden act=%b exp=0", out_valid); end
    if (dlen(3) !== (AW+1)'(3)) begin failures++; $display("FAIL order_len3 act=%0d exp=3", dlen(3)); end
    if (free_cnt !== (AW+1)'(TC - 3)) begin failures++; $display("FAIL order_free act=%0d exp=%0d", free_cnt, TC - 3); end
    release_en = NI'(1) << 3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL order_valid i=%0d act=%b exp=1", i, out_valid); end
      if (data_o !== v[i]) begin failures++; $display("FAIL order_data i=%0d act=%h exp=%h", i, data_o, v[i]); end
      tick();
    end
    out_ready = 1'b0;
    release_en = '0;
  endtask

  task automatic test_round_robin();
    int exp_g [4] = '{1, 2, 1, 2};
    push(rdata(1)); push(rdata(1)); push(rdata(2)); push(rdata(2));
    release_en = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g = m_grant();
      #1;
      checks += 2;
      if (int'(data_o[IW-1:0]) !== exp_g[i]) begin failures++; $display("FAIL rr_grant i=%0d act=%0d exp=%0d", i, data_o[IW-1:0], exp_g[i]); end
      if (g < 0 || data_o !== mq[g][0]) begin failures++; $display("FAIL rr_data i=%0d act=%h exp_id=%0d", i, data_o, g); end
      tick();
    end
    out_ready = 1'b0;
    release_en = '0;
  endtask

  task automatic test_full();
    int g;
    for (int i = 0; i < TC; i++) push(rdata(i % NI));
    #1;
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready act=%b exp=0", in_ready); end
    if (free_cnt !== '0) begin failures++; $display("FAIL full_free act=%0d exp=0", free_cnt); end
    release_en = '1;
    out_ready = 1'b1;
    g = m_grant();
    in_valid = 1'b1;
    data_i = rdata(g);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle_ready act=%b exp=0", in_ready); end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop_ready act=%b exp=1", in_ready); end
    if (free_cnt !== (AW+1)'(1)) begin failures++; $display("FAIL full_after_pop_free act=%0d exp=1", free_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < TC - 1; i++) begin
      g = m_grant();
      #1;
      checks++;
      if (g < 0 || data_o !== mq[g][0]) begin failures++; $display("FAIL drain_data i=%0d act=%h exp_id=%0d", i, data_o, g); end
      tick();
    end
    #1;
    checks++;
    if (free_cnt !== (AW+1)'(TC)) begin failures++; $display("FAIL drain_free act=%0d exp=%0d", free_cnt, TC); end
    out_ready = 1'b0;
    release_en = '0;
  endtask

  task automatic test_push_pop_same();
    logic [SW-1:0] e = rdata(5);
    logic [SW-1:0] d = rdata(5);
    push(e);
    in_valid = 1'b1;
    data_i = d;
    release_en = NI'(1) << 5;
    out_ready = 1'b1;
    #1;
    checks++;
    if (data_o !== e) begin failures++; $display("FAIL same_pop_data act=%h exp=%h", data_o, e); end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks += 3;
    if (dlen(5) !== (AW+1)'(1)) begin failures++; $display("FAIL same_len act=%0d exp=1", dlen(5)); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL same_valid act=%b exp=1", out_valid); end
    if (data_o !== d) begin failures++; $display("FAIL same_new_head act=%h exp=%h", data_o, d); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    release_en = '0;
  endtask

  task automatic test_hold();
    logic [SW-1:0] p = rdata(7);
    logic [SW-1:0] q = rdata(7);
    push(p); push(q);
    release_en = NI'(1) << 7;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid i=%0d act=%b exp=1", i, out_valid); end
      if (data_o !== p) begin failures++; $display("FAIL hold_data i=%0d act=%h exp=%h", i, data_o, p); end
      if (dlen(7) !== (AW+1)'(2)) begin failures++; $display("FAIL hold_len i=%0d act=%0d exp=2", i, dlen(7)); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks += 2;
    if (dlen(7) !== (AW+1)'(1)) begin failures++; $display("FAIL hold_pop_len act=%0d exp=1", dlen(7)); end
    if (data_o !== q) begin failures++; $display("FAIL hold_next_data act=%h exp=%h", data_o, q); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    release_en = '0;
  endtask

`ifdef SIMMEM_ID_QUEUE_PER_ID_CAP_EN
  task automatic test_cap();
    for (int i = 0; i < MPI; i++) push(rdata(0));
    data_i = rdata(0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL cap_id0_ready act=%b exp=0", in_ready); end
    data_i = rdata(1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL cap_id1_ready act=%b exp=1", in_ready); end
    release_en = '1;
    out_ready = 1'b1;
    repeat (MPI) tick();
    out_ready = 1'b0;
    release_en = '0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int g;
      release_en = NI'($urandom());
      in_valid = ($urandom_range(0, 3) != 0);
      data_i = rdata($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) == 0);
      g = m_grant();
      #1;
      checks += 3;
      if (out_valid !== (g >= 0)) begin failures++; $display("FAIL rnd_valid c=%0d act=%b exp=%b", c, out_valid, g >= 0); end
      if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready c=%0d act=%b exp=%b", c, in_ready, m_ready()); end
      if (free_cnt !== (AW+1)'(TC - m_total())) begin failures++; $display("FAIL rnd_free c=%0d act=%0d exp=%0d", c, free_cnt, TC - m_total()); end
      if (g >= 0) begin
        checks++;
        if (data_o !== mq[g][0]) begin failures++; $display("FAIL rnd_data c=%0d act=%h exp=%h", c, data_o, mq[g][0]); end
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (dlen(k) !== (AW+1)'(mq[k].size())) begin failures++; $display("FAIL rnd_len c=%0d id=%0d act=%0d exp=%0d", c, k, dlen(k), mq[k].size()); end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    push(rdata(9));
    release_en = NI'(1) << 9;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid act=%b exp=0", out_valid); end
    if (free_cnt !== (AW+1)'(TC)) begin failures++; $display("FAIL midrst_free act=%0d exp=%0d", free_cnt, TC); end
    if (dlen(9) !== '0) begin failures++; $display("FAIL midrst_len act=%0d exp=0", dlen(9)); end
    for (int k = 0; k < NI; k++) mq[k].delete();
    mrr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    release_en = '0;
    #1;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_round_robin();
    test_full();
    test_push_pop_same();
    test_hold();
`ifdef SIMMEM_ID_QUEUE_PER_ID_CAP_EN
    test_cap();
`endif
    test_random();
    test_reset_mid();
    test_in_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
